// File: rtl/operand_hazard_unit_pkg.sv
// Shared pipeline defines: opcodes, forwarding-select encoding and the
// bit layout of one hazard-tracking stage entry.
package operand_hazard_unit_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_e;

    localparam int unsigned FWD_W = 2;

    typedef enum logic [FWD_W-1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // Entry layout, LSB first: valid, wen, is_load, then dst address.
    localparam int unsigned ENT_VALID = 0;
    localparam int unsigned ENT_WEN   = 1;
    localparam int unsigned ENT_LOAD  = 2;
    localparam int unsigned ENT_DST   = 3;

    function automatic int unsigned ent_width(input int unsigned reg_aw);
        return reg_aw + ENT_DST;
    endfunction

endpackage

// File: rtl/operand_hazard_unit_if.sv
// Decode-side bus of the hazard unit: instruction operands in, stall and
// forwarding selects out.
interface operand_hazard_unit_if
    import operand_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned CNT_W  = 16
);
    logic                     d_valid;
    logic [NSRC*REG_AW-1:0]   d_src;
    logic [NSRC-1:0]          d_src_used;
    logic [REG_AW-1:0]        d_dst;
    logic                     d_wen;
    logic                     d_is_load;
    logic                     flush;
    logic                     stall;
    logic [NSRC*FWD_W-1:0]    fwd_sel;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output d_valid, d_src, d_src_used, d_dst, d_wen, d_is_load, flush,
        input  stall, fwd_sel, stall_cnt
    );

    modport slave (
        input  d_valid, d_src, d_src_used, d_dst, d_wen, d_is_load, flush,
        output stall, fwd_sel, stall_cnt
    );
endinterface

// File: rtl/operand_hazard_unit_stage_reg.sv
// One downstream stage entry register; a bubble or reset clears it to an
// all-zero (invalid) entry.
module hazard_stage_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end
endmodule

// File: rtl/operand_hazard_unit.sv
// Operand hazard unit: tracks in-flight destinations, selects forwarding
// sources per operand and stalls decode for one cycle on load-use.
module operand_hazard_unit
    import operand_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_hazard_unit_if.slave bus
);
    localparam int unsigned EW = ent_width(REG_AW);

    logic [EW-1:0]               ent   [DEPTH];
    logic [EW-1:0]               ent_d [DEPTH];
    logic [EW-1:0]               dec_ent;
    logic [NSRC-1:0][DEPTH-1:0]  match;
    logic [REG_AW-1:0]           src;
    logic                        stall_raw;
    logic                        stall_int;
    logic                        take;
    fwd_sel_e                    sel;
    logic [NSRC*FWD_W-1:0]       fwd;
    logic [CNT_W-1:0]            cnt;

    always_comb begin
        dec_ent                     = '0;
        dec_ent[ENT_VALID]          = bus.d_valid;
        dec_ent[ENT_WEN]            = bus.d_wen;
        dec_ent[ENT_LOAD]           = bus.d_is_load;
        dec_ent[ENT_DST +: REG_AW]  = bus.d_dst;
    end

    assign take = bus.d_valid & ~stall_int & ~bus.flush;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign ent_d[k] = dec_ent;
        end else begin : g_tail
            assign ent_d[k] = ent[k-1];
        end

        hazard_stage_reg #(.W(EW)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .bubble ((k == 0) ? ~take : 1'b0),
            .d      (ent_d[k]),
            .q      (ent[k])
        );
    end

    // Register 0 is hardwired zero, so it never produces a dependency.
    always_comb begin
        match = '0;
        src   = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            src = bus.d_src[i*REG_AW +: REG_AW];
            for (int unsigned k = 0; k < DEPTH; k++) begin
                match[i][k] = bus.d_valid & bus.d_src_used[i]
                            & ent[k][ENT_VALID] & ent[k][ENT_WEN]
                            & (ent[k][ENT_DST +: REG_AW] == src)
                            & (src != '0);
            end
        end
    end

    always_comb begin
        stall_raw = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            stall_raw = stall_raw | (match[i][0] & ent[0][ENT_LOAD]);
        end
    end

    assign stall_int = stall_raw & ~bus.flush & ~rst;

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwd = '0;
        sel = FWD_RF;
        for (int unsigned i = 0; i < NSRC; i++) begin
            sel = FWD_RF;
            for (int unsigned k = DEPTH; k > 0; k--) begin
                if (match[i][k-1]) begin
                    sel = fwd_sel_e'(FWD_W'(k));
                end
            end
            if (!stall_int && !rst) begin
                fwd[i*FWD_W +: FWD_W] = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (stall_int && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.stall     = stall_int;
    assign bus.fwd_sel   = fwd;
    assign bus.stall_cnt = cnt;

endmodule

// File: doc/operand_hazard_unit.md
OPERAND_HAZARD_UNIT -- requirements
Module: operand_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register address width.
REQ-002 SHALL have parameter DEPTH, default 3, meaning tracked downstream stages (EX, MEM, WB; index 0 = youngest).
REQ-003 SHALL have parameter NSRC, default 2, meaning source operand channels (srcA, srcB, ...).
REQ-004 SHALL have parameter CNT_W, default 16, meaning stall counter width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port d_valid, input, 1, decode stage holds a real instruction.
REQ-008 SHALL have port d_src, input, NSRC*REG_AW, packed source addresses; channel i at bits [i*REG_AW +: REG_AW].
REQ-009 SHALL have port d_src_used, input, NSRC, per-channel "operand actually read" (e.g. J-type reads none).
REQ-010 SHALL have port d_dst, input, REG_AW, destination address.
REQ-011 SHALL have port d_wen, input, 1, instruction writes d_dst.
REQ-012 SHALL have port d_is_load, input, 1, result available only after stage 1 (MEM).
REQ-013 SHALL have port flush, input, 1, kill decode instruction (branch taken).
REQ-014 SHALL have port stall, output, 1, hold fetch/decode this cycle.
REQ-015 SHALL have port fwd_sel, output, NSRC*2, per-channel select: 0 = register file, k = forward from stage k-1.
REQ-016 SHALL have port stall_cnt, output, CNT_W, saturating count of stall cycles.

Function
REQ-017 SHALL keep a DEPTH-entry shift pipeline of {valid, wen, dst, is_load}, entry 0 fed from decode.
REQ-018 SHALL treat address 0 as never matching (hardwired zero register).
REQ-019 SHALL define match(i,k) = d_valid & d_src_used[i] & entry[k].valid & entry[k].wen & entry[k].dst == src_i & src_i != 0.
REQ-020 SHALL assert stall combinationally when match(i,0) & entry[0].is_load for any channel i, and flush is low.
REQ-021 SHALL drive fwd_sel[i] combinationally as k+1 for the lowest k with match(i,k), else 0; when stall is high fwd_sel is don't-care-free and SHALL be 0.
REQ-022 SHALL on each clock shift entry[k] into entry[k+1]; entry DEPTH-1 is discarded.
REQ-023 SHALL load entry 0 with the decode instruction when d_valid & ~stall & ~flush; otherwise load a bubble (valid = 0).
REQ-024 SHALL give flush priority over stall: flush high forces stall low and a bubble into entry 0.
REQ-025 SHALL increment stall_cnt by one each cycle stall is high, saturating at all-ones (no wrap).
REQ-026 SHALL keep one cycle of stall per load-use pair: after the bubble, the load sits in entry 1 and is forwarded with fwd_sel = 2.
REQ-027 SHALL apply all rules identically and independently to every channel; both channels matching is legal.

Reset
REQ-028 SHALL on rst clear all entry valid bits, clear stall_cnt to 0; stall = 0 and fwd_sel = 0 during and after reset until a valid entry exists.
REQ-029 SHALL let rst override flush, stall and d_valid in the same cycle; reset mid-stall drops the pending hazard.

Structure
REQ-030 SHALL place the fwd_sel encoding constants (FWD_RF = 0, FWD_EX = 1, FWD_MEM = 2, FWD_WB = 3) and the stage-entry field layout in the shared pipeline defines header alongside the opcode defines.
REQ-031 SHALL use one sub-module, hazard_stage_reg, a single entry register with bubble-insert and reset, instantiated DEPTH times.

Verification
REQ-032 SHALL test: ADD writes r3, next ADD reads srcA = r3 -> fwd_sel[0] = 1, stall = 0.
REQ-033 SHALL test: LW writes r8, next instruction reads srcB = r8 -> stall = 1 for exactly 1 cycle, bubble in entry 0, next cycle fwd_sel[1] = 2, stall_cnt = 1.
REQ-034 SHALL test: write r0 then read r0, and J-type with d_src_used = 0 reading r5 after a write to r5 -> fwd_sel = 0, stall = 0.
REQ-035 SHALL test: r4 written in stages 0 and 2, srcA = r4 -> fwd_sel[0] = 1 (youngest wins); srcA = srcB = r4 -> both channels 1.
REQ-036 SHALL test: load-use hazard with flush high -> stall = 0, entry 0 bubble; rst asserted during stall -> all outputs 0 next cycle.
REQ-037 SHALL test: CNT_W = 4 with 20 consecutive stall cycles -> stall_cnt holds at 15.
